// File: rtl/bus_load_unit.sv
// Bus destination unit: loads the bus word into AR/AC/PC/DR/R/IR and commits DRAM writes via an ack handshake.
// Optional feature macro: BUS_LOAD_INC_EN (enables PC/AR increment through inc_ctrl).
module bus_load_unit #(
  parameter int DATA_W      = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_data,
  input  logic [3:0]        load_ctrl,
  input  logic [1:0]        inc_ctrl,
  input  logic              dram_ack,
  output logic [DATA_W-1:0] ar,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] dr,
  output logic [DATA_W-1:0] r,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic              dram_we,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [3:0] LD_AR = 4'd1, LD_AC = 4'd2, LD_PC = 4'd3, LD_DR = 4'd4;
  localparam logic [3:0] LD_R  = 4'd5, LD_IRAM = 4'd6, LD_WR = 4'd7, LD_IR = 4'd8;
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} wstate_t;

  wstate_t    state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       capture, err_ev, err_pend, err_pend_n, err_n;
  logic       inc_pc, inc_ar;

`ifdef BUS_LOAD_INC_EN
  assign inc_pc = inc_ctrl[0];
  assign inc_ar = inc_ctrl[1];
`else
  logic unused_inc;
  assign unused_inc = ^inc_ctrl;
  assign inc_pc     = 1'b0;
  assign inc_ar     = 1'b0;
`endif

  // Register file: a bus load overrides a same-cycle increment of that register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar <= '0; ac <= '0; pc <= '0; dr <= '0; r <= '0; ir <= '0;
    end else begin
      if (load_ctrl == LD_AR)  ar <= bus_data;
      else if (inc_ar)         ar <= ar + DATA_W'(1);
      if (load_ctrl == LD_PC)  pc <= bus_data;
      else if (inc_pc)         pc <= pc + DATA_W'(1);
      if (load_ctrl == LD_AC)  ac <= bus_data;
      if (load_ctrl == LD_DR)  dr <= bus_data;
      if (load_ctrl == LD_R)   r  <= bus_data;
      if (load_ctrl == LD_IR)  ir <= bus_data;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    err_ev  = (load_ctrl == LD_IRAM);
    case (state)
      IDLE: if (load_ctrl == LD_WR) begin
        capture = 1'b1;
        cnt_n   = '0;
        state_n = REQ;
      end
      REQ: begin
        if (load_ctrl == LD_WR) err_ev = 1'b1;
        if (dram_ack) state_n = DONE;
        else if (cnt == TO_LAST) begin
          state_n = IDLE;
          err_ev  = 1'b1;
        end else cnt_n = cnt + 8'd1;
      end
      DONE: begin
        // The next write may be accepted while done is showing.
        if (load_ctrl == LD_WR) begin
          capture = 1'b1;
          cnt_n   = '0;
          state_n = REQ;
        end else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // err must never coincide with done; an error raised on the ack edge is shown a cycle later.
    err_n      = (err_ev | err_pend) & (state_n != DONE);
    err_pend_n = (err_ev | err_pend) & (state_n == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      dram_we    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_pend   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dram_we  <= (state_n == REQ);
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
      err      <= err_n;
      err_pend <= err_pend_n;
      if (capture) begin
        dram_addr  <= ar;
        dram_wdata <= bus_data;
      end
    end
  end
endmodule

// File: tb/tb_bus_load_unit.sv
// Self-checking bench for bus_load_unit: transaction-level reference model, per-cycle compare, directed literals and random traffic.
module tb_bus_load_unit;
  localparam int W = 16;
  localparam int T = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  bus_data = '0;
  logic [3:0]    load_ctrl = '0;
  logic [1:0]    inc_ctrl = '0;
  logic          dram_ack = 1'b0;
  logic [W-1:0]  ar, ac, pc, dr, r, ir, dram_addr, dram_wdata;
  logic          dram_we, busy, done, err;

  bus_load_unit #(.DATA_W(W), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .bus_data(bus_data), .load_ctrl(load_ctrl),
    .inc_ctrl(inc_ctrl), .dram_ack(dram_ack), .ar(ar), .ac(ac), .pc(pc),
    .dr(dr), .r(r), .ir(ir), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_we(dram_we), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

`ifdef BUS_LOAD_INC_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  int nchk = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // Reference model: a write is a transaction with an age in REQ; outcomes are decided from that age.
  logic [W-1:0] m_ar, m_ac, m_pc, m_dr, m_r, m_ir, m_addr, m_data;
  logic m_we, m_busy, m_done, m_err;
  bit   wr_open, err_owed;
  int   req_age;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      {m_ar, m_ac, m_pc, m_dr, m_r, m_ir, m_addr, m_data} = '0;
      {m_we, m_busy, m_done, m_err} = '0;
      wr_open = 0; err_owed = 0; req_age = 0;
    end else begin
      bit ev, done_now;
      logic [W-1:0] old_ar;
      old_ar = m_ar;
      ev = (load_ctrl == 4'd6);
      done_now = 0;
      if (INC_EN && inc_ctrl[1]) m_ar = m_ar + 1'b1;
      if (INC_EN && inc_ctrl[0]) m_pc = m_pc + 1'b1;
      case (load_ctrl)
        4'd1: m_ar = bus_data;
        4'd2: m_ac = bus_data;
        4'd3: m_pc = bus_data;
        4'd4: m_dr = bus_data;
        4'd5: m_r  = bus_data;
        4'd8: m_ir = bus_data;
        default: ;
      endcase
      if (wr_open) begin
        if (load_ctrl == 4'd7) ev = 1;
        if (dram_ack) begin wr_open = 0; done_now = 1; end
        else if (req_age + 1 == T) begin wr_open = 0; ev = 1; end
        else req_age++;
      end else if (load_ctrl == 4'd7) begin
        wr_open = 1; req_age = 0; m_addr = old_ar; m_data = bus_data;
      end
      ev = ev || err_owed;
      m_err    = done_now ? 1'b0 : ev;
      err_owed = done_now && ev;
      m_done = done_now;
      m_we   = wr_open;
      m_busy = wr_open || done_now;
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      chk("ar", ar, m_ar);   chk("ac", ac, m_ac);   chk("pc", pc, m_pc);
      chk("dr", dr, m_dr);   chk("r", r, m_r);      chk("ir", ir, m_ir);
      chk("dram_addr", dram_addr, m_addr);  chk("dram_wdata", dram_wdata, m_data);
      chk("dram_we", 16'(dram_we), 16'(m_we)); chk("busy", 16'(busy), 16'(m_busy));
      chk("done", 16'(done), 16'(m_done));     chk("err", 16'(err), 16'(m_err));
    end
  end

  task automatic cyc(input logic [3:0] lc, input logic [W-1:0] bd, input logic [1:0] inc, input logic ack);
    @(negedge clk);
    load_ctrl = lc; bus_data = bd; inc_ctrl = inc; dram_ack = ack;
    @(posedge clk);
    #3;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;
    #1;
    chk("rst_pc", pc, 16'h0);  chk("rst_we", 16'(dram_we), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);

    // Load PC
    cyc(4'd3, 16'h1234, 2'd0, 1'b0);
    chk("ld_pc", pc, 16'h1234);  chk("ld_ar_zero", ar, 16'h0);  chk("ld_ir_zero", ir, 16'h0);

    // Increment wrap and load-wins
    cyc(4'd3, 16'hFFFF, 2'd0, 1'b0);
    cyc(4'd0, 16'h0000, 2'd1, 1'b0);
    chk("pc_inc_wrap", pc, INC_EN ? 16'h0000 : 16'hFFFF);
    cyc(4'd3, 16'hFFFF, 2'd0, 1'b0);
    cyc(4'd3, 16'h0040, 2'd1, 1'b0);
    chk("pc_load_wins", pc, 16'h0040);

    // Acked write: ack sampled on the third edge after the write code
    cyc(4'd1, 16'h0010, 2'd0, 1'b0);
    cyc(4'd7, 16'hBEEF, 2'd0, 1'b0);
    chk("wr_we1", 16'(dram_we), 16'h1);
    chk("wr_addr", dram_addr, 16'h0010);  chk("wr_data", dram_wdata, 16'hBEEF);
    cyc(4'd0, 16'h0000, 2'd0, 1'b0);  chk("wr_we2", 16'(dram_we), 16'h1);
    cyc(4'd0, 16'h0000, 2'd0, 1'b0);  chk("wr_we3", 16'(dram_we), 16'h1);
    cyc(4'd0, 16'h0000, 2'd0, 1'b1);
    chk("wr_we_fall", 16'(dram_we), 16'h0);  chk("wr_done", 16'(done), 16'h1);
    chk("wr_done_noerr", 16'(err), 16'h0);
    cyc(4'd0, 16'h0000, 2'd0, 1'b0);
    chk("wr_done_once", 16'(done), 16'h0);  chk("wr_idle", 16'(busy), 16'h0);
    chk("wr_addr_hold", dram_addr, 16'h0010);

    // Timeout
    cyc(4'd7, 16'h5555, 2'd0, 1'b0);
    n = 0;
    while (dram_we && n < 20) begin
      n++;
      cyc(4'd0, 16'h0000, 2'd0, 1'b0);
    end
    chk("to_we_cycles", 16'(n), 16'(T));
    chk("to_err", 16'(err), 16'h1);  chk("to_busy", 16'(busy), 16'h0);
    cyc(4'd0, 16'h0000, 2'd0, 1'b0);
    chk("to_err_once", 16'(err), 16'h0);

    // Errors during REQ leave the write intact
    cyc(4'd7, 16'hCAFE, 2'd0, 1'b0);
    cyc(4'd7, 16'h1111, 2'd0, 1'b0);
    chk("busy_wr_err", 16'(err), 16'h1);  chk("busy_wr_data", dram_wdata, 16'hCAFE);
    cyc(4'd6, 16'h2222, 2'd0, 1'b0);
    chk("iram_err", 16'(err), 16'h1);  chk("iram_we", 16'(dram_we), 16'h1);
    cyc(4'd0, 16'h0000, 2'd0, 1'b1);
    chk("req_done", 16'(done), 16'h1);  chk("req_done_noerr", 16'(err), 16'h0);

    // Reset mid-REQ
    cyc(4'd7, 16'h7777, 2'd0, 1'b0);
    cyc(4'd0, 16'h0000, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_we", 16'(dram_we), 16'h0);  chk("rst_mid_busy", 16'(busy), 16'h0);
    chk("rst_mid_addr", dram_addr, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      cyc(4'd0, 16'h0000, 2'd0, 1'b1);
      chk("rst_no_done", 16'(done), 16'h0);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] lc;
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
      end
      lc = ($urandom_range(0, 9) < 3) ? 4'd7 : 4'($urandom_range(0, 15));
      cyc(lc, 16'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
